// File: rtl/aes_key_inv_sched.sv
// AES-128 round-key source: expands the cipher key forward to round 10, then
// streams round keys 10..0 to a consumer by stepping the schedule backwards.

module aes_sbox_keyExp (
    input  logic [31:0] word,
    output logic [31:0] sub_rot
);
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // RotWord is folded into the byte selection feeding the lookups.
    always_comb begin
        sub_rot = {SBOX[word[23:16]], SBOX[word[15:8]], SBOX[word[7:0]], SBOX[word[31:24]]};
    end
endmodule

module aes_key_inv_sched_chk (
    input logic         CLK,
    input logic         RST,
    input logic         busy,
    input logic         keyValid,
    input logic         keyReady,
    input logic         done,
    input logic [3:0]   round,
    input logic [127:0] keyOut
);
    a_round_range: assert property (@(posedge CLK) disable iff (RST) round <= 4'd10);
    a_valid_busy:  assert property (@(posedge CLK) disable iff (RST) keyValid |-> busy);
    a_done_idle:   assert property (@(posedge CLK) disable iff (RST) done |-> (!keyValid && !busy));
    a_hold:        assert property (@(posedge CLK) (!RST && keyValid && !keyReady) |=> ($stable(keyOut) && $stable(round)));
    a_reset:       assert property (@(posedge CLK) RST |=> (!busy && !keyValid && !done && round == 4'd0 && keyOut == 128'h0));
endmodule

module aes_key_inv_sched #(
    parameter int NR = 10
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         start,
    input  logic [127:0] cipherKey,
    output logic         busy,
    output logic [127:0] keyOut,
    output logic [3:0]   round,
    output logic         keyValid,
    input  logic         keyReady,
    output logic         done
);
    localparam logic [3:0] LAST_ROUND = 4'(NR);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        EMIT   = 2'd2
    } state_t;

    state_t       state_r;
    logic [127:0] key_r;
    logic [3:0]   round_r;
    logic         busy_r;
    logic         valid_r;
    logic         done_r;

    logic [31:0]  n0_s, n1_s, n2_s, n3_s;
    logic [31:0]  sbox_in_s, sbox_out_s, t_s;
    logic [31:0]  f0_s, f1_s, f2_s, f3_s;
    logic [31:0]  p0_s, p1_s, p2_s, p3_s;
    logic [3:0]   round_inc_s, rcon_idx_s;
    logic [127:0] fwd_key_s, inv_key_s;

    function automatic logic [31:0] rcon(input logic [3:0] idx);
        logic [7:0] rc;
        case (idx)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return {rc, 24'h000000};
    endfunction

    // Word split and S-box operand select: w3 going forward, recovered w3 going back.
    always_comb begin
        n0_s        = key_r[127:96];
        n1_s        = key_r[95:64];
        n2_s        = key_r[63:32];
        n3_s        = key_r[31:0];
        p3_s        = n3_s ^ n2_s;
        round_inc_s = round_r + 4'd1;
        case (state_r)
            EMIT: begin
                sbox_in_s  = p3_s;
                rcon_idx_s = round_r;
            end
            default: begin
                sbox_in_s  = n3_s;
                rcon_idx_s = round_inc_s;
            end
        endcase
    end

    aes_sbox_keyExp u_sbox (
        .word    (sbox_in_s),
        .sub_rot (sbox_out_s)
    );

    // Forward and inverse schedule steps built around the shared S-box result.
    always_comb begin
        t_s       = sbox_out_s ^ rcon(rcon_idx_s);
        f0_s      = n0_s ^ t_s;
        f1_s      = n1_s ^ f0_s;
        f2_s      = n2_s ^ f1_s;
        f3_s      = n3_s ^ f2_s;
        fwd_key_s = {f0_s, f1_s, f2_s, f3_s};
        p2_s      = n2_s ^ n1_s;
        p1_s      = n1_s ^ n0_s;
        p0_s      = n0_s ^ t_s;
        inv_key_s = {p0_s, p1_s, p2_s, p3_s};
    end

    // Control FSM with key register, round counter and registered handshake outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r <= IDLE;
            key_r   <= 128'h0;
            round_r <= 4'd0;
            busy_r  <= 1'b0;
            valid_r <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        key_r   <= cipherKey;
                        round_r <= 4'd0;
                        busy_r  <= 1'b1;
                        state_r <= EXPAND;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                EXPAND: begin
                    key_r   <= fwd_key_s;
                    round_r <= round_inc_s;
                    if (round_inc_s >= LAST_ROUND) begin
                        valid_r <= 1'b1;
                        state_r <= EMIT;
                    end else begin
                        state_r <= EXPAND;
                    end
                end
                EMIT: begin
                    if (keyReady) begin
                        if (round_r == 4'd0) begin
                            valid_r <= 1'b0;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                            state_r <= IDLE;
                        end else begin
                            key_r   <= inv_key_s;
                            round_r <= round_r - 4'd1;
                        end
                    end else begin
                        state_r <= EMIT;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    round_r <= 4'd0;
                    busy_r  <= 1'b0;
                    valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign keyOut   = key_r;
    assign round    = round_r;
    assign busy     = busy_r;
    assign keyValid = valid_r;
    assign done     = done_r;

    aes_key_inv_sched_chk u_chk (
        .CLK      (CLK),
        .RST      (RST),
        .busy     (busy),
        .keyValid (keyValid),
        .keyReady (keyReady),
        .done     (done),
        .round    (round),
        .keyOut   (keyOut)
    );
endmodule

// File: tb/tb_aes_key_inv_sched.sv
// Scoreboard bench for aes_key_inv_sched: a reference key expansion built from
// GF(2^8) arithmetic predicts every round key, the done pulse and the latency.

module tb_aes_key_inv_sched;
    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic         start = 1'b0;
    logic [127:0] cipherKey = 128'h0;
    logic         busy;
    logic [127:0] keyOut;
    logic [3:0]   round;
    logic         keyValid;
    logic         keyReady = 1'b1;
    logic         done;

    aes_key_inv_sched #(.NR(10)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .start     (start),
        .cipherKey (cipherKey),
        .busy      (busy),
        .keyOut    (keyOut),
        .round     (round),
        .keyValid  (keyValid),
        .keyReady  (keyReady),
        .done      (done)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [3:0]   rnd;
        logic [127:0] key;
    } exp_t;

    exp_t         exp_q[$];
    int           rise_q[$];
    int           cyc = 0;
    int           n_checks = 0;
    int           n_fail = 0;
    logic         mon_en = 1'b0;
    logic         ready_rand = 1'b0;
    logic         done_due = 1'b0;
    logic         prev_valid = 1'b0;
    logic         prev_ready = 1'b0;
    logic [127:0] prev_key = 128'h0;
    logic [3:0]   prev_round = 4'd0;
    logic [127:0] rk [0:10];
    exp_t         mon_e;
    exp_t         drv_e;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, expv);
        end
    endtask

    task automatic unexpected(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got an event at cycle %0d, expected none", name, cyc);
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box from its definition: multiplicative inverse (x^254) then the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0]  inv;
        logic [7:0]  s;
        logic [15:0] d;
        inv = 8'h01;
        for (int i = 0; i < 254; i++) inv = gmul(inv, x);
        d = {inv, inv};
        s = 8'h63;
        for (int n = 0; n < 5; n++) s = s ^ d[15-n -: 8];
        return s;
    endfunction

    task automatic expand(input logic [127:0] k);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0]), sbox(t[31:24])} ^ {rc, 24'h000000};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
        if (ready_rand) keyReady = 1'($urandom_range(0, 1));
    endtask

    // Issue an accepted start and queue the keys expected for rounds 10 down to last.
    task automatic start_key(input logic [127:0] k, input int last);
        expand(k);
        for (int r = 10; r >= last; r--) begin
            drv_e.rnd = 4'(r);
            drv_e.key = rk[r];
            exp_q.push_back(drv_e);
        end
        rise_q.push_back(cyc + 11);
        cipherKey = k;
        start = 1'b1;
        tick();
        start = 1'b0;
        cipherKey = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic pulse_start(input logic [127:0] k);
        cipherKey = k;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_round(input logic [3:0] r);
        int n;
        n = 0;
        while (!(keyValid && round == r) && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) unexpected("wait_round_timeout");
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!done && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) unexpected("wait_done_timeout");
    endtask

    task automatic override(input int idx, input logic [127:0] k);
        drv_e = exp_q[idx];
        drv_e.key = k;
        exp_q[idx] = drv_e;
    endtask

    // Monitor: pops the scoreboard on every transfer and checks hold, latency and done.
    always @(negedge CLK) begin
        if (mon_en) begin
            chk("done_pulse", 128'(done), 128'(done_due));
            done_due = 1'b0;
            if (keyValid && !prev_valid) begin
                if (rise_q.size() == 0) unexpected("keyValid_rise");
                else chk("valid_latency", 128'(cyc), 128'(rise_q.pop_front()));
            end
            if (keyValid && prev_valid && !prev_ready) begin
                chk("hold_key", keyOut, prev_key);
                chk("hold_round", 128'(round), 128'(prev_round));
            end
            if (keyValid && keyReady && !RST) begin
                if (exp_q.size() == 0) begin
                    unexpected("key_transfer");
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("round", 128'(round), 128'(mon_e.rnd));
                    chk("key", keyOut, mon_e.key);
                    if (mon_e.rnd == 4'd0) done_due = 1'b1;
                end
            end
            prev_valid = keyValid;
            prev_ready = keyReady;
            prev_key   = keyOut;
            prev_round = round;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with a start request pending must still leave everything cleared.
        RST = 1'b1;
        start = 1'b1;
        cipherKey = {$urandom, $urandom, $urandom, $urandom};
        repeat (3) tick();
        RST = 1'b0;
        start = 1'b0;
        chk("reset_busy", 128'(busy), 128'h0);
        chk("reset_valid", 128'(keyValid), 128'h0);
        chk("reset_done", 128'(done), 128'h0);
        chk("reset_round", 128'(round), 128'h0);
        chk("reset_key", keyOut, 128'h0);
        mon_en = 1'b1;
        tick();

        // FIPS-197 vector with published round keys pinned.
        start_key(128'h2b7e151628aed2a6abf7158809cf4f3c, 0);
        override(0, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        override(1, 128'hac7766f319fadc2128d12941575c006e);
        override(9, 128'ha0fafe1788542cb123a339392a6c7605);
        override(10, 128'h2b7e151628aed2a6abf7158809cf4f3c);
        wait_done();
        repeat (2) tick();

        // Backpressure at round 10 for five cycles.
        start_key({$urandom, $urandom, $urandom, $urandom}, 0);
        wait_round(4'd10);
        keyReady = 1'b0;
        repeat (5) tick();
        keyReady = 1'b1;
        wait_done();
        repeat (2) tick();

        // Start requests while busy must be ignored.
        ready_rand = 1'b1;
        start_key({$urandom, $urandom, $urandom, $urandom}, 0);
        repeat (2) tick();
        pulse_start({$urandom, $urandom, $urandom, $urandom});
        wait_round(4'd5);
        pulse_start({$urandom, $urandom, $urandom, $urandom});
        wait_done();
        ready_rand = 1'b0;
        keyReady = 1'b1;
        repeat (2) tick();

        // Reset while emitting round 6.
        start_key({$urandom, $urandom, $urandom, $urandom}, 7);
        wait_round(4'd6);
        RST = 1'b1;
        keyReady = 1'b0;
        tick();
        RST = 1'b0;
        keyReady = 1'b1;
        chk("midrst_valid", 128'(keyValid), 128'h0);
        chk("midrst_busy", 128'(busy), 128'h0);
        chk("midrst_round", 128'(round), 128'h0);
        chk("midrst_key", keyOut, 128'h0);
        chk("midrst_done", 128'(done), 128'h0);
        repeat (30) tick();

        // All-zero key, then a new start in the very cycle done is high.
        start_key(128'h0, 0);
        override(0, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
        wait_done();
        start_key({$urandom, $urandom, $urandom, $urandom}, 0);
        wait_done();
        repeat (2) tick();

        // Random keys with random consumer readiness.
        ready_rand = 1'b1;
        for (int i = 0; i < 3; i++) begin
            start_key({$urandom, $urandom, $urandom, $urandom}, 0);
            wait_done();
            repeat (3) tick();
        end
        ready_rand = 1'b0;
        keyReady = 1'b1;
        repeat (5) tick();

        chk("scoreboard_empty", 128'(exp_q.size()), 128'h0);
        chk("latency_queue_empty", 128'(rise_q.size()), 128'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/aes_key_inv_sched.md
AES_KEY_INV_SCHED -- requirements
Module: aes_key_inv_sched

Interface
REQ-001 The block SHALL have one parameter: NR, default 10, number of AES rounds; only 10 (AES-128) is supported.
REQ-002 The block SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port RST, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: load request, sampled only in IDLE.
REQ-005 The block SHALL have port cipherKey, input, 128 bits: AES-128 cipher key, captured when start is accepted; word 0 is [127:96].
REQ-006 The block SHALL have port busy, output, 1 bit: high in every state other than IDLE.
REQ-007 The block SHALL have port keyOut, output, 128 bits: the current round key, same word order as cipherKey.
REQ-008 The block SHALL have port round, output, 4 bits: round index of keyOut, from 10 down to 0.
REQ-009 The block SHALL have port keyValid, output, 1 bit: keyOut and round are valid.
REQ-010 The block SHALL have port keyReady, input, 1 bit: the consumer accepts keyOut on a cycle where keyValid and keyReady are both high.
REQ-011 The block SHALL have port done, output, 1 bit: one-cycle pulse after the round-0 key is accepted.

Function
REQ-012 The block SHALL implement a three-state FSM with states IDLE, EXPAND and EMIT.
REQ-013 In IDLE with start=1, the block SHALL capture cipherKey into the key register, clear the round counter to 0, and go to EXPAND.
- start SHALL be ignored in every other state.
REQ-014 Each EXPAND cycle SHALL apply the forward AES-128 step to the key register, then increment the round counter.
- Forward step: t = SubWord(RotWord(w3)) ^ rcon(r+1); w0' = w0^t; w1' = w1^w0'; w2' = w2^w1'; w3' = w3^w2'.
- rcon(1..10) = 01,02,04,08,10,20,40,80,1b,36 in byte [31:24]; all other bytes 0.
REQ-015 EXPAND SHALL last exactly 10 cycles, after which the block SHALL be in EMIT with round=10 and keyOut holding the round-10 key.
- keyValid SHALL therefore rise 11 cycles after the cycle in which start was accepted.
REQ-016 In EMIT, keyValid SHALL be 1; while keyReady=0, keyOut and round SHALL hold stable.
REQ-017 On an EMIT transfer with round=r>0, the block SHALL replace keyOut with the previous round key using the inverse step, and set round to r-1.
- Inverse step: p3 = n3^n2; p2 = n2^n1; p1 = n1^n0; p0 = n0 ^ SubWord(RotWord(p3)) ^ rcon(r).
REQ-018 Back-to-back transfers with keyReady held at 1 SHALL deliver one key per cycle: rounds 10 down to 0 in 11 consecutive cycles.
REQ-019 On an EMIT transfer with round=0, the block SHALL go to IDLE, drop keyValid in the next cycle, and pulse done=1 for exactly that cycle.
REQ-020 A start asserted in the same cycle as done SHALL be accepted.
REQ-021 The forward and inverse steps SHALL share a single instance of the codebase's aes_sbox_keyExp S-box (4 bytes, RotWord applied at its input), with its input multiplexed by state.
REQ-022 Round counter arithmetic SHALL be 4-bit unsigned, and the counter SHALL never leave 0..10.
- An rcon index outside 1..10 SHALL yield 0.
REQ-023 keyOut SHALL remain at its last value in IDLE; consumers SHALL qualify it with keyValid.

Reset
REQ-024 With RST=1 at a rising edge, the block SHALL clear the key register, round and all control outputs on that edge, regardless of state or of start.
- Resulting state: IDLE, busy=0, keyValid=0, done=0, round=0, keyOut=0.
REQ-025 A reset during EXPAND or EMIT SHALL abort the sequence, and no further keyValid or done SHALL be produced for that key.

Verification
REQ-026 The bench SHALL cover FIPS-197 key expansion with keyReady=1.
- Stimulus: cipherKey=2b7e151628aed2a6abf7158809cf4f3c, one-cycle start.
- Response: 11 cycles later, keyOut=d014f9a8c9ee2589e13f0cc8b6630ca6 with round=10.
- Next cycle: keyOut=ac7766f319fadc2128d12941575c006e with round=9.
- Round 1: keyOut=a0fafe1788542cb123a339392a6c7605.
- Round 0: keyOut=2b7e1516...09cf4f3c, followed by a done pulse.
REQ-027 The bench SHALL cover backpressure: keyReady=0 for 5 cycles at round=10, then 1.
- Response: keyOut and round stable for all 5 cycles; the sequence then completes unchanged.
REQ-028 The bench SHALL cover start while busy: start pulsed during EXPAND and during EMIT with a different cipherKey.
- Response: ignored; output keys are unchanged.
REQ-029 The bench SHALL cover reset mid-EMIT: RST=1 at round=6.
- Response: next cycle keyValid=0, busy=0, round=0, keyOut=0; no done pulse.
REQ-030 The bench SHALL cover an all-zero key: cipherKey=0.
- Response: round-10 key = b4ef5bcb3e92e21123e951cf6f8f188e; reverse stream ends at 0 with done.
REQ-031 The bench SHALL cover start coincident with done.
- Response: the second key is captured, and its round-10 key appears 11 cycles later.
